// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the memory-port arbiter.
package mem_arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int PADDR_W = 22;
    localparam int WORD_W  = 36;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational rotating-base priority picker: first pending index at or after
// base (round-robin) or from index 0 (fixed priority).
module mem_arbiter_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] base,
    input  logic             mode,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    int start_idx;
    int idx;

    always_comb begin
        winner    = '0;
        idx       = 0;
        start_idx = mode ? int'(base) : 0;
        // Scan from the far end so the closest pending port to start_idx wins last.
        for (int k = N - 1; k >= 0; k--) begin
            idx = start_idx + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (pending[idx]) begin
                winner = IDX_W'(idx);
            end
        end
        any = |pending;
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter in front of the single memory port: IDLE -> ISSUE -> RELEASE,
// round-robin or fixed priority, with a non-existent-memory timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NPORTS   = 2,
    parameter int ADDR_W   = PADDR_W,
    parameter int DATA_W   = WORD_W,
    parameter int ARB_MODE = ARB_RR,
    parameter int TIMEOUT  = 255
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NPORTS*ADDR_W-1:0]                     req_addr,
    input  logic [NPORTS*DATA_W-1:0]                     req_wdata,
    input  logic [NPORTS-1:0]                            req_read,
    input  logic [NPORTS-1:0]                            req_write,
    output logic [DATA_W-1:0]                            req_rdata,
    output logic [NPORTS-1:0]                            req_read_ack,
    output logic [NPORTS-1:0]                            req_write_ack,
    output logic [NPORTS-1:0]                            req_nxm,
    output logic [ADDR_W-1:0]                            mem_addr,
    output logic [DATA_W-1:0]                            mem_write_data,
    output logic                                         mem_read,
    output logic                                         mem_write,
    input  logic [DATA_W-1:0]                            mem_read_data,
    input  logic                                         mem_read_ack,
    input  logic                                         mem_write_ack,
    output logic [((NPORTS > 1) ? $clog2(NPORTS) : 1)-1:0] grant_id,
    output logic                                         busy
);

    localparam int GID_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GID_W-1:0] LAST_PORT = GID_W'(NPORTS - 1);
    localparam logic             RR_MODE   = (ARB_MODE != ARB_FIXED);

    arb_state_t          state_reg, state_next;
    logic [GID_W-1:0]    grant_reg, grant_next;
    logic [GID_W-1:0]    last_grant_reg, last_grant_next;
    logic [TMR_W-1:0]    timer_reg, timer_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic                mem_read_reg, mem_read_next;
    logic                mem_write_reg, mem_write_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic [NPORTS-1:0]   read_ack_reg, read_ack_next;
    logic [NPORTS-1:0]   write_ack_reg, write_ack_next;
    logic [NPORTS-1:0]   nxm_reg, nxm_next;
    logic                busy_reg;

    logic [ADDR_W-1:0]   addr_arr  [NPORTS];
    logic [DATA_W-1:0]   wdata_arr [NPORTS];
    logic [NPORTS-1:0]   pending;
    logic [GID_W-1:0]    rr_base;
    logic [GID_W-1:0]    winner;
    logic                any_pending;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign pending = req_read | req_write;
    assign rr_base = (last_grant_reg == LAST_PORT) ? '0 : last_grant_reg + GID_W'(1);

    mem_arbiter_rr_pick #(
        .N     (NPORTS),
        .IDX_W (GID_W)
    ) u_pick (
        .pending (pending),
        .base    (rr_base),
        .mode    (RR_MODE),
        .winner  (winner),
        .any     (any_pending)
    );

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        timer_next      = timer_reg;
        mem_addr_next   = mem_addr_reg;
        wdata_next      = wdata_reg;
        mem_read_next   = mem_read_reg;
        mem_write_next  = mem_write_reg;
        rdata_next      = rdata_reg;
        read_ack_next   = '0;
        write_ack_next  = '0;
        nxm_next        = '0;
        case (state_reg)
            IDLE: begin
                if (any_pending) begin
                    grant_next     = winner;
                    mem_addr_next  = addr_arr[winner];
                    wdata_next     = wdata_arr[winner];
                    // Read takes precedence when a port raises both strobes.
                    mem_read_next  = req_read[winner];
                    mem_write_next = !req_read[winner];
                    timer_next     = '0;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                timer_next = timer_reg + TMR_W'(1);
                if (mem_read_reg && mem_read_ack) begin
                    read_ack_next[grant_reg] = 1'b1;
                    rdata_next               = mem_read_data;
                    mem_read_next            = 1'b0;
                    state_next               = RELEASE;
                end else if (mem_write_reg && mem_write_ack) begin
                    write_ack_next[grant_reg] = 1'b1;
                    mem_write_next            = 1'b0;
                    state_next                = RELEASE;
                end else if ((TIMEOUT != 0) && (timer_reg == TMR_LAST)) begin
                    nxm_next[grant_reg] = 1'b1;
                    mem_read_next       = 1'b0;
                    mem_write_next      = 1'b0;
                    state_next          = RELEASE;
                end
            end
            RELEASE: begin
                last_grant_next = grant_reg;
                state_next      = IDLE;
            end
            default: begin
                mem_read_next  = 1'b0;
                mem_write_next = 1'b0;
                state_next     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= LAST_PORT;
            timer_reg      <= '0;
            mem_addr_reg   <= '0;
            wdata_reg      <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            rdata_reg      <= '0;
            read_ack_reg   <= '0;
            write_ack_reg  <= '0;
            nxm_reg        <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            timer_reg      <= timer_next;
            mem_addr_reg   <= mem_addr_next;
            wdata_reg      <= wdata_next;
            mem_read_reg   <= mem_read_next;
            mem_write_reg  <= mem_write_next;
            rdata_reg      <= rdata_next;
            read_ack_reg   <= read_ack_next;
            write_ack_reg  <= write_ack_next;
            nxm_reg        <= nxm_next;
            busy_reg       <= (state_next != IDLE);
        end
    end

    assign req_rdata      = rdata_reg;
    assign req_read_ack   = read_ack_reg;
    assign req_write_ack  = write_ack_reg;
    assign req_nxm        = nxm_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_write_data = wdata_reg;
    assign mem_read       = mem_read_reg;
    assign mem_write      = mem_write_reg;
    assign grant_id       = (NPORTS == 1) ? '0 : grant_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin instance (TIMEOUT=8) and a fixed-priority instance.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    // Round-robin instance
    logic [43:0] req_addr = '0;
    logic [71:0] req_wdata = '0;
    logic [1:0]  req_read = '0;
    logic [1:0]  req_write = '0;
    logic [35:0] req_rdata;
    logic [1:0]  req_read_ack, req_write_ack, req_nxm;
    logic [21:0] mem_addr;
    logic [35:0] mem_write_data;
    logic        mem_read, mem_write;
    logic [35:0] mem_read_data = '0;
    logic        mem_read_ack = 1'b0;
    logic        mem_write_ack = 1'b0;
    logic [0:0]  grant_id;
    logic        busy;

    // Fixed-priority instance
    logic [43:0] fx_req_addr = '0;
    logic [1:0]  fx_req_read = '0;
    logic [35:0] fx_req_rdata;
    logic [1:0]  fx_read_ack, fx_write_ack, fx_nxm;
    logic [21:0] fx_mem_addr;
    logic [35:0] fx_mem_write_data;
    logic        fx_mem_read, fx_mem_write;
    logic        fx_mem_read_ack = 1'b0;
    logic [0:0]  fx_grant_id;
    logic        fx_busy;

    int checks = 0;
    int passed = 0;

    mem_arbiter #(.NPORTS(2), .ADDR_W(22), .DATA_W(36), .ARB_MODE(1), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_read(req_read), .req_write(req_write),
        .req_rdata(req_rdata), .req_read_ack(req_read_ack),
        .req_write_ack(req_write_ack), .req_nxm(req_nxm),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack),
        .mem_write_ack(mem_write_ack),
        .grant_id(grant_id), .busy(busy)
    );

    mem_arbiter #(.NPORTS(2), .ADDR_W(22), .DATA_W(36), .ARB_MODE(0), .TIMEOUT(8)) dut_fx (
        .clk(clk), .reset(reset),
        .req_addr(fx_req_addr), .req_wdata(72'd0),
        .req_read(fx_req_read), .req_write(2'b00),
        .req_rdata(fx_req_rdata), .req_read_ack(fx_read_ack),
        .req_write_ack(fx_write_ack), .req_nxm(fx_nxm),
        .mem_addr(fx_mem_addr), .mem_write_data(fx_mem_write_data),
        .mem_read(fx_mem_read), .mem_write(fx_mem_write),
        .mem_read_data(36'o555), .mem_read_ack(fx_mem_read_ack),
        .mem_write_ack(1'b0),
        .grant_id(fx_grant_id), .busy(fx_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until the RR instance raises a strobe, at most 12 cycles.
    task automatic wait_strobe(output int n);
        n = 0;
        while (!(mem_read || mem_write) && n < 12) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        tick();
        checks++; if ({mem_read, mem_write, busy} !== 3'b000) $display("FAIL reset_strobes: got %b want 000", {mem_read, mem_write, busy}); else passed++;
        checks++; if ({req_read_ack, req_write_ack, req_nxm} !== 6'b0) $display("FAIL reset_acks: got %b want 0", {req_read_ack, req_write_ack, req_nxm}); else passed++;
        checks++; if ({grant_id, mem_addr, req_rdata} !== 59'd0) $display("FAIL reset_regs: got %h want 0", {grant_id, mem_addr, req_rdata}); else passed++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_rr_alternate;
        int n;
        int exp;
        req_addr  = {22'o200, 22'o100};
        req_read  = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp = t % 2;
            wait_strobe(n);
            checks++; if (mem_read !== 1'b1) $display("FAIL rr_strobe: got %b want 1 (txn %0d)", mem_read, t); else passed++;
            checks++; if (grant_id !== exp[0:0]) $display("FAIL rr_grant: got %0d want %0d (txn %0d)", grant_id, exp, t); else passed++;
            mem_read_ack = 1'b1;
            mem_read_data = 36'(t + 1);
            tick();
            mem_read_ack = 1'b0;
            checks++; if (req_read_ack !== (2'b01 << exp)) $display("FAIL rr_ack: got %b want %b (txn %0d)", req_read_ack, 2'b01 << exp, t); else passed++;
            $display("rr txn %0d: grant %0d ack %b", t, grant_id, req_read_ack);
            if (t == 3) req_read = 2'b00;
        end
        tick();
        tick();
    endtask

    task automatic test_read;
        req_addr[21:0] = 22'o1000;
        req_read = 2'b01;
        tick();
        checks++; if ({mem_read, mem_addr} !== {1'b1, 22'o1000}) $display("FAIL read_issue: got %b/%o want 1/1000", mem_read, mem_addr); else passed++;
        tick();
        mem_read_ack = 1'b1;
        mem_read_data = 36'o123456654321;
        tick();
        mem_read_ack = 1'b0;
        mem_read_data = '0;
        req_read = 2'b00;
        checks++; if (req_read_ack !== 2'b01) $display("FAIL read_ack: got %b want 01", req_read_ack); else passed++;
        checks++; if (req_rdata !== 36'o123456654321) $display("FAIL read_data: got %o want 123456654321", req_rdata); else passed++;
        checks++; if (mem_read !== 1'b0) $display("FAIL read_drop: got %b want 0", mem_read); else passed++;
        $display("read txn: port 0 addr %o data %o", mem_addr, req_rdata);
        tick();
        checks++; if (req_read_ack !== 2'b00) $display("FAIL read_pulse: got %b want 00", req_read_ack); else passed++;
        checks++; if (req_rdata !== 36'o123456654321) $display("FAIL read_hold: got %o want 123456654321", req_rdata); else passed++;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL read_idle: got %b want 0", busy); else passed++;
    endtask

    task automatic test_write;
        int n;
        req_addr[43:22]  = 22'o2000;
        req_wdata[71:36] = 36'o777777777777;
        req_write = 2'b10;
        wait_strobe(n);
        checks++; if ({mem_write, mem_read} !== 2'b10) $display("FAIL write_strobe: got %b want 10", {mem_write, mem_read}); else passed++;
        checks++; if ({mem_addr, mem_write_data} !== {22'o2000, 36'o777777777777}) $display("FAIL write_bus: got %o/%o want 2000/777777777777", mem_addr, mem_write_data); else passed++;
        mem_write_ack = 1'b1;
        tick();
        mem_write_ack = 1'b0;
        req_write = 2'b00;
        checks++; if ({req_write_ack, req_read_ack} !== 4'b1000) $display("FAIL write_ack: got %b want 1000", {req_write_ack, req_read_ack}); else passed++;
        $display("write txn: port 1 addr %o data %o", mem_addr, mem_write_data);
        tick();
        tick();
    endtask

    task automatic test_timeout;
        int n;
        req_addr[21:0] = 22'o3000;
        req_read = 2'b01;
        wait_strobe(n);
        checks++; if (mem_read !== 1'b1) $display("FAIL nxm_strobe: got %b want 1", mem_read); else passed++;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                checks++; if ({req_nxm, mem_read} !== 3'b001) $display("FAIL nxm_early: got %b want 001 (cycle %0d)", {req_nxm, mem_read}, k); else passed++;
            end
        end
        checks++; if ({req_nxm, mem_read} !== 3'b010) $display("FAIL nxm_pulse: got %b want 010", {req_nxm, mem_read}); else passed++;
        $display("nxm txn: port 0 addr %o nxm %b", mem_addr, req_nxm);
        req_read = 2'b00;
        tick();
        checks++; if (req_nxm !== 2'b00) $display("FAIL nxm_clear: got %b want 00", req_nxm); else passed++;
        req_addr[43:22] = 22'o4000;
        req_read = 2'b10;
        wait_strobe(n);
        checks++; if ({mem_read, grant_id} !== 2'b11) $display("FAIL nxm_next_grant: got %b want 11", {mem_read, grant_id}); else passed++;
        mem_read_ack = 1'b1;
        mem_read_data = 36'o42;
        tick();
        mem_read_ack = 1'b0;
        req_read = 2'b00;
        checks++; if ({req_read_ack, req_rdata} !== {2'b10, 36'o42}) $display("FAIL nxm_next_ack: got %b/%o want 10/42", req_read_ack, req_rdata); else passed++;
        $display("post-nxm txn: port 1 data %o", req_rdata);
        tick();
        tick();
    endtask

    task automatic test_spurious;
        int n;
        mem_read_ack = 1'b1;
        mem_read_data = 36'o7070;
        tick();
        mem_read_ack = 1'b0;
        checks++; if ({busy, req_read_ack, req_rdata} !== {3'b000, 36'o42}) $display("FAIL spur_idle: got %b/%b/%o want 0/00/42", busy, req_read_ack, req_rdata); else passed++;
        req_addr[21:0] = 22'o5000;
        req_read = 2'b01;
        wait_strobe(n);
        mem_write_ack = 1'b1;
        tick();
        tick();
        mem_write_ack = 1'b0;
        checks++; if ({req_read_ack, req_write_ack} !== 4'b0000) $display("FAIL spur_wrong_ack: got %b want 0000", {req_read_ack, req_write_ack}); else passed++;
        checks++; if ({mem_read, busy} !== 2'b11) $display("FAIL spur_state: got %b want 11", {mem_read, busy}); else passed++;
        mem_read_ack = 1'b1;
        mem_read_data = 36'o1234;
        tick();
        mem_read_ack = 1'b0;
        req_read = 2'b00;
        checks++; if ({req_read_ack, req_rdata} !== {2'b01, 36'o1234}) $display("FAIL spur_real_ack: got %b/%o want 01/1234", req_read_ack, req_rdata); else passed++;
        $display("spurious txn: port 0 data %o", req_rdata);
        tick();
        tick();
    endtask

    task automatic test_reset_mid_issue;
        int n;
        req_addr = {22'o600, 22'o500};
        req_read = 2'b11;
        wait_strobe(n);
        checks++; if (grant_id !== 1'b1) $display("FAIL rst_pre_grant: got %0d want 1", grant_id); else passed++;
        reset = 1'b0;
        #1;
        checks++; if ({mem_read, busy, req_read_ack, grant_id} !== 5'b0) $display("FAIL rst_async: got %b want 00000", {mem_read, busy, req_read_ack, grant_id}); else passed++;
        tick();
        reset = 1'b1;
        wait_strobe(n);
        checks++; if ({mem_read, grant_id, mem_addr} !== {1'b1, 1'b0, 22'o500}) $display("FAIL rst_first_grant: got %b/%0d/%o want 1/0/500", mem_read, grant_id, mem_addr); else passed++;
        mem_read_ack = 1'b1;
        tick();
        mem_read_ack = 1'b0;
        req_read = 2'b00;
        checks++; if (req_read_ack !== 2'b01) $display("FAIL rst_ack: got %b want 01", req_read_ack); else passed++;
        $display("post-reset txn: grant %0d ack %b", grant_id, req_read_ack);
        tick();
        tick();
    endtask

    task automatic test_fixed;
        int n;
        fx_req_addr = {22'o20, 22'o10};
        fx_req_read = 2'b11;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (!fx_mem_read && n < 12) begin
                tick();
                n++;
            end
            checks++; if ({fx_mem_read, fx_grant_id} !== 2'b10) $display("FAIL fx_grant: got %b want 10 (txn %0d)", {fx_mem_read, fx_grant_id}, t); else passed++;
            fx_mem_read_ack = 1'b1;
            tick();
            fx_mem_read_ack = 1'b0;
            checks++; if (fx_read_ack !== 2'b01) $display("FAIL fx_ack: got %b want 01 (txn %0d)", fx_read_ack, t); else passed++;
            $display("fixed txn %0d: grant %0d ack %b", t, fx_grant_id, fx_read_ack);
            if (t == 3) fx_req_read = 2'b00;
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_rr_alternate();
        test_read();
        test_write();
        test_timeout();
        test_spurious();
        test_reset_mid_issue();
        test_fixed();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
